// File: rtl/ysyx_24110006_idu_queue.sv
// Instruction buffer between fetch and decode: a circular queue of fetched beats
// with a combinational decoder on the head entry.
module ysyx_24110006_idu_queue #(
    parameter int DEPTH = 2,
    parameter bit RV32E = 1'b0
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [31:0]                i_inst,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_imm,
    input  logic                       i_exception,
    input  logic [3:0]                 i_mcause,
    output logic                       o_valid,
    input  logic                       i_ready,
    input  logic                       i_stall,
    input  logic                       i_flush,
    output logic [6:0]                 o_op,
    output logic [2:0]                 o_func,
    output logic [4:0]                 o_reg_rs1,
    output logic [4:0]                 o_reg_rs2,
    output logic [4:0]                 o_reg_rd,
    output logic                       o_reg_wen,
    output logic [31:0]                o_imm,
    output logic [31:0]                o_pc,
    output logic [1:0]                 o_csr_t,
    output logic [11:0]                o_csr,
    output logic                       o_mret,
    output logic                       o_exception,
    output logic [3:0]                 o_mcause,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a beat moves when its valid and ready are both high at a rising
    // edge; o_ready/o_valid depend only on the registered count, never on i_valid/i_ready.

    logic [31:0]   inst_q   [DEPTH];
    logic [31:0]   pc_q     [DEPTH];
    logic [31:0]   imm_q    [DEPTH];
    logic          exc_q    [DEPTH];
    logic [3:0]    mcause_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          enq, deq;

    assign o_ready = (count_q < CW'(DEPTH));
    assign o_valid = (count_q != '0);
    assign o_count = count_q;
    assign enq     = i_valid & o_ready & ~i_flush;
    assign deq     = o_valid & i_ready & ~i_stall & ~i_flush;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
        if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
        if (enq && !deq)      count_d = count_q + CW'(1);
        else if (deq && !enq) count_d = count_q - CW'(1);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (enq) begin
            inst_q[wr_ptr_q]   <= i_inst;
            pc_q[wr_ptr_q]     <= i_pc;
            imm_q[wr_ptr_q]    <= i_imm;
            exc_q[wr_ptr_q]    <= i_exception;
            mcause_q[wr_ptr_q] <= i_mcause;
        end
    end

    logic [31:0] head;
    logic        cls_i, cls_r, cls_l, cls_s, cls_jal, cls_jalr;
    logic        cls_auipc, cls_lui, cls_b, cls_csr, cls_fence;
    logic        wr_class, use_rs1, use_rs2, bad_reg;
    logic        illegal, brk, ecall, any_exc;

    assign head = inst_q[rd_ptr_q];

    always_comb begin
        o_op      = head[6:0];
        o_func    = head[14:12];
        o_reg_rd  = head[11:7];
        o_reg_rs1 = head[19:15];
        o_reg_rs2 = head[24:20];
        o_csr     = head[31:20];
        o_pc      = pc_q[rd_ptr_q];
        o_imm     = imm_q[rd_ptr_q];

        cls_i     = (o_op == 7'b0010011);
        cls_r     = (o_op == 7'b0110011);
        cls_l     = (o_op == 7'b0000011);
        cls_s     = (o_op == 7'b0100011);
        cls_jal   = (o_op == 7'b1101111);
        cls_jalr  = (o_op == 7'b1100111);
        cls_auipc = (o_op == 7'b0010111);
        cls_lui   = (o_op == 7'b0110111);
        cls_b     = (o_op == 7'b1100011);
        cls_csr   = (o_op == 7'b1110011);
        cls_fence = (o_op == 7'b0001111);

        wr_class = cls_i | cls_r | cls_l | cls_jal | cls_jalr | cls_auipc | cls_lui;
        use_rs1  = cls_r | cls_i | cls_l | cls_s | cls_b | cls_jalr;
        use_rs2  = cls_r | cls_s | cls_b;
        // RV32E only has x0..x15, so bit 4 of any register field actually read or written is illegal.
        bad_reg  = RV32E & ((wr_class & o_reg_rd[4]) | (use_rs1 & o_reg_rs1[4]) |
                            (use_rs2 & o_reg_rs2[4]));
        illegal  = ~(wr_class | cls_s | cls_b | cls_csr | cls_fence) | bad_reg;
        brk      = (head == 32'h0010_0073);
        ecall    = (head == 32'h0000_0073);

        o_mret     = (head == 32'h3020_0073);
        o_csr_t    = {o_mret, cls_csr & (o_func != 3'd0)};

        any_exc     = exc_q[rd_ptr_q] | illegal | brk | ecall;
        o_exception = o_valid & any_exc;
        if (exc_q[rd_ptr_q]) o_mcause = mcause_q[rd_ptr_q];
        else if (illegal)    o_mcause = 4'd2;
        else if (brk)        o_mcause = 4'd3;
        else if (ecall)      o_mcause = 4'd11;
        else                 o_mcause = 4'd0;

        o_reg_wen = wr_class & ~o_exception;
    end
endmodule

// File: doc/ysyx_24110006_idu_queue.md
YSYX_24110006_IDU_QUEUE -- requirements
Module: ysyx_24110006_idu_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: instruction-buffer entries, power of two, range 2..16.
REQ-002 SHALL have parameter RV32E, default 0: when 1, register indices 16..31 are illegal.
REQ-003 SHALL have ports i_clock input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have ports i_reset input 1, synchronous active-high reset.
REQ-005 SHALL have upstream ports:
- i_valid in 1
- o_ready out 1
- i_inst in 32
- i_pc in 32
- i_imm in 32
- i_exception in 1
- i_mcause in 4
REQ-006 SHALL have downstream ports:
- o_valid out 1
- i_ready in 1
- i_stall in 1
- i_flush in 1
REQ-007 SHALL have decode outputs:
- o_op out 7
- o_func out 3
- o_reg_rs1 out 5
- o_reg_rs2 out 5
- o_reg_rd out 5
- o_reg_wen out 1
- o_imm out 32
- o_pc out 32
- o_csr_t out 2
- o_csr out 12
- o_mret out 1
- o_exception out 1
- o_mcause out 4
- o_count out $clog2(DEPTH)+1, occupied entries

Function
REQ-008 SHALL store {inst, pc, imm, exception, mcause} per entry in a circular buffer with read pointer, write pointer and occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-009 SHALL drive o_ready = (count < DEPTH) and o_valid = (count != 0), both from registered count only, with no combinational path from i_valid or i_ready.
REQ-010 SHALL enqueue when i_valid & o_ready & !i_flush, and dequeue when o_valid & i_ready & !i_stall & !i_flush.
REQ-011 SHALL update count +1 on enqueue only, -1 on dequeue only, and leave it unchanged on simultaneous enqueue and dequeue.
REQ-012 SHALL refuse to enqueue when full, even if a dequeue occurs in the same cycle; there is no pass-through.
REQ-013 SHALL have no empty bypass: minimum latency from accepted beat to o_valid is 1 cycle.
REQ-014 SHALL hold all head-entry outputs stable while o_valid & (!i_ready | i_stall).
REQ-015 SHALL, on i_flush, set count and both pointers to 0 at the next edge, and drop any same-cycle upstream beat; i_flush has priority over enqueue, dequeue and i_stall.
REQ-016 SHALL decode combinationally from the head entry:
- op = inst[6:0], func = inst[14:12], rd = inst[11:7]
- rs1 = inst[19:15], rs2 = inst[24:20], csr = inst[31:20]
- o_pc and o_imm taken from the stored entry
REQ-017 SHALL classify opcode classes:
- I 0010011, R 0110011, L 0000011, S 0100011
- JAL 1101111, JALR 1100111, AUIPC 0010111, LUI 0110111
- B 1100011, CSR 1110011, FENCE 0001111
REQ-018 SHALL set o_mret = (inst == 32'h30200073), o_csr_t[0] = CSR & (func != 0), and o_csr_t[1] = o_mret.
REQ-019 SHALL detect local exceptions:
- illegal: opcode outside REQ-017; or, with RV32E=1, bit 4 set in any used register field
- used fields: rd for reg_wen classes; rs1 for R/I/L/S/B/JALR; rs2 for R/S/B
- breakpoint: inst == 32'h00100073
- ecall: inst == 32'h00000073
REQ-020 SHALL prioritise mcause as: stored upstream exception (stored mcause) > illegal (2) > breakpoint (3) > ecall (11); o_exception is the OR of all four.
REQ-021 SHALL set o_reg_wen = (I|R|L|JAL|JALR|AUIPC|LUI) & !o_exception.
REQ-022 SHALL NOT leave entry contents undefined on outputs: when o_valid=0, o_exception SHALL be 0.

Reset
REQ-023 SHALL, while i_reset=1 at an edge, clear count and both pointers, giving o_valid=0, o_ready=1, o_count=0 and o_exception=0.
REQ-024 SHALL NOT require entry payload storage to be reset.
REQ-025 SHALL discard a beat presented during the reset cycle; reset mid-stream behaves as a flush.

Verification
REQ-026 SHALL cover this scenario: push 0x00500093 (addi x1,x0,5) at pc 0x80000000 into an empty queue with i_ready=1 -> o_valid=1 one cycle later, rd=1, o_reg_wen=1, o_exception=0, dequeued the next cycle.
REQ-027 SHALL cover this scenario: DEPTH=4, i_ready=0, stream 6 beats -> o_ready=0 after 4 accepts, o_count=4; raise i_ready -> in-order output and pointer wrap verified.
REQ-028 SHALL cover this scenario: full queue with i_flush=1 and i_valid=1 in the same cycle -> next cycle o_count=0, o_valid=0, o_ready=1, beat dropped.
REQ-029 SHALL cover these exception cases:
- inst 0x00100073 -> o_exception=1, o_mcause=3
- inst 0xFFFFFFFF -> o_mcause=2
- i_exception=1 with i_mcause=1 on an ecall -> o_mcause=1
REQ-030 SHALL cover this scenario: RV32E=1, inst 0x01000813 (addi x16,x0,16) -> o_mcause=2, o_reg_wen=0; with RV32E=0 -> no exception.
REQ-031 SHALL cover this scenario: i_stall=1 with i_ready=1 for 3 cycles while o_valid=1 -> head outputs and o_count unchanged; release -> one dequeue per cycle.
